// File: rtl/gol_pkg.sv
// Shared Game-of-Life definitions: default board/pattern geometry, stamp modes,
// stamper FSM states and the per-cell combine rule.
package gol_pkg;

  localparam int unsigned GOL_MAX_X   = 64;
  localparam int unsigned GOL_MAX_Y   = 48;
  localparam int unsigned GOL_PAT_W   = 8;
  localparam int unsigned GOL_PAT_H   = 8;
  localparam int unsigned GOL_COORD_W = 8;

  localparam logic [1:0] MODE_SET     = 2'b00;
  localparam logic [1:0] MODE_CLEAR   = 2'b01;
  localparam logic [1:0] MODE_TOGGLE  = 2'b10;
  localparam logic [1:0] MODE_REPLACE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STAMP = 2'd1,
    ST_DONE  = 2'd2
  } stamp_state_e;

  // New value of one board cell; cells outside the write mask keep their value.
  function automatic logic combine_bit(input logic [1:0] mode, input logic s,
                                       input logic p, input logic en);
    logic r;
    r = s;
    if (en) begin
      case (mode)
        MODE_SET:    r = s | p;
        MODE_CLEAR:  r = s & ~p;
        MODE_TOGGLE: r = s ^ p;
        default:     r = p;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/stamp_row_map.sv
// Maps one latched pattern row onto a board row: target row index, row-valid
// flag, write mask and data. PATTERN_STAMPER_WRAP_EN selects toroidal wrap.
module stamp_row_map
  import gol_pkg::*;
#(
  parameter int unsigned MAX_X   = GOL_MAX_X,
  parameter int unsigned MAX_Y   = GOL_MAX_Y,
  parameter int unsigned PAT_W   = GOL_PAT_W,
  parameter int unsigned PAT_H   = GOL_PAT_H,
  parameter int unsigned COORD_W = GOL_COORD_W,
  localparam int unsigned ROW_W  = (PAT_H > 1) ? $clog2(PAT_H) : 1,
  localparam int unsigned X_W    = (MAX_X > 1) ? $clog2(MAX_X) : 1,
  localparam int unsigned Y_W    = (MAX_Y > 1) ? $clog2(MAX_Y) : 1
) (
  input  logic [COORD_W-1:0] cursor_x,
  input  logic [COORD_W-1:0] cursor_y,
  input  logic [ROW_W-1:0]   row,
  input  logic [PAT_W-1:0]   pat_row,
  output logic [Y_W-1:0]     row_idx_c,
  output logic               row_valid_c,
  output logic [MAX_X-1:0]   wmask_c,
  output logic [MAX_X-1:0]   wdata_c
);

  // One extra bit so cursor + offset never overflows.
  localparam int unsigned SUM_W = COORD_W + 1;

  logic [SUM_W-1:0] sum_y;
  logic [SUM_W-1:0] sum_x;
  logic [X_W-1:0]   col;

  always_comb begin
    sum_y   = SUM_W'(cursor_y) + SUM_W'(row);
    sum_x   = '0;
    col     = '0;
    wmask_c = '0;
    wdata_c = '0;
`ifdef PATTERN_STAMPER_WRAP_EN
    row_valid_c = 1'b1;
    row_idx_c   = Y_W'(32'(sum_y) % MAX_Y);
`else
    row_valid_c = (32'(sum_y) < MAX_Y);
    row_idx_c   = Y_W'(sum_y);
`endif
    for (int unsigned dx = 0; dx < PAT_W; dx++) begin
      sum_x = SUM_W'(cursor_x) + SUM_W'(dx);
`ifdef PATTERN_STAMPER_WRAP_EN
      col          = X_W'(32'(sum_x) % MAX_X);
      wmask_c[col] = 1'b1;
      wdata_c[col] = pat_row[dx];
`else
      if (32'(sum_x) < MAX_X) begin
        col          = X_W'(sum_x);
        wmask_c[col] = 1'b1;
        wdata_c[col] = pat_row[dx];
      end
`endif
    end
  end

endmodule

// File: rtl/pattern_stamper.sv
// Owns the Game-of-Life board; stamps a latched pattern one row per clock or
// loads a whole generation. PATTERN_STAMPER_WRAP_EN enables toroidal wrap.
module pattern_stamper
  import gol_pkg::*;
#(
  parameter int unsigned MAX_X   = GOL_MAX_X,
  parameter int unsigned MAX_Y   = GOL_MAX_Y,
  parameter int unsigned PAT_W   = GOL_PAT_W,
  parameter int unsigned PAT_H   = GOL_PAT_H,
  parameter int unsigned COORD_W = GOL_COORD_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [1:0]               mode,
  input  logic [PAT_W*PAT_H-1:0]   pattern_mat,
  input  logic [COORD_W-1:0]       cursor_x,
  input  logic [COORD_W-1:0]       cursor_y,
  input  logic                     load,
  input  logic [MAX_X*MAX_Y-1:0]   next_state,
  output logic [MAX_X*MAX_Y-1:0]   state,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned BOARD_W = MAX_X * MAX_Y;
  localparam int unsigned PAT_N   = PAT_W * PAT_H;
  localparam int unsigned ROW_W   = (PAT_H > 1) ? $clog2(PAT_H) : 1;
  localparam int unsigned Y_W     = (MAX_Y > 1) ? $clog2(MAX_Y) : 1;

  stamp_state_e         fsm_q, fsm_d;
  logic [BOARD_W-1:0]   board_q, board_d;
  logic [1:0]           mode_q, mode_d;
  logic [PAT_N-1:0]     pat_q, pat_d;
  logic [COORD_W-1:0]   cx_q, cx_d;
  logic [COORD_W-1:0]   cy_q, cy_d;
  logic [ROW_W-1:0]     row_q, row_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [PAT_W-1:0]     pat_row_c;
  logic [Y_W-1:0]       row_idx_c;
  logic                 row_valid_c;
  logic [MAX_X-1:0]     wmask_c;
  logic [MAX_X-1:0]     wdata_c;
  logic [MAX_X-1:0]     cur_row_c;
  logic [MAX_X-1:0]     new_row_c;
  int unsigned          row_base_c;

  assign pat_row_c = pat_q[32'(row_q) * PAT_W +: PAT_W];

  stamp_row_map #(
    .MAX_X   (MAX_X),
    .MAX_Y   (MAX_Y),
    .PAT_W   (PAT_W),
    .PAT_H   (PAT_H),
    .COORD_W (COORD_W)
  ) u_row_map (
    .cursor_x    (cx_q),
    .cursor_y    (cy_q),
    .row         (row_q),
    .pat_row     (pat_row_c),
    .row_idx_c   (row_idx_c),
    .row_valid_c (row_valid_c),
    .wmask_c     (wmask_c),
    .wdata_c     (wdata_c)
  );

  // Merge the mapped pattern row into the addressed board row.
  always_comb begin
    row_base_c = row_valid_c ? 32'(row_idx_c) * MAX_X : 0;
    cur_row_c  = board_q[row_base_c +: MAX_X];
    new_row_c  = cur_row_c;
    for (int unsigned x = 0; x < MAX_X; x++) begin
      new_row_c[x] = combine_bit(mode_q, cur_row_c[x], wdata_c[x], wmask_c[x]);
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    board_d = board_q;
    mode_d  = mode_q;
    pat_d   = pat_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    row_d   = row_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    unique case (fsm_q)
      ST_IDLE: begin
        if (load) begin
          board_d = next_state;
        end else if (start) begin
          mode_d = mode;
          pat_d  = pattern_mat;
          cx_d   = cursor_x;
          cy_d   = cursor_y;
          row_d  = '0;
          fsm_d  = ST_STAMP;
          busy_d = 1'b1;
        end
      end
      ST_STAMP: begin
        if (row_valid_c) begin
          board_d[row_base_c +: MAX_X] = new_row_c;
        end
        if (row_q == ROW_W'(PAT_H - 1)) begin
          row_d  = '0;
          fsm_d  = ST_DONE;
          done_d = 1'b1;
        end else begin
          row_d  = row_q + ROW_W'(1);
          busy_d = 1'b1;
        end
      end
      ST_DONE: fsm_d = ST_IDLE;
      default: fsm_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q   <= ST_IDLE;
      board_q <= '0;
      mode_q  <= MODE_SET;
      pat_q   <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      row_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      board_q <= board_d;
      mode_q  <= mode_d;
      pat_q   <= pat_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      row_q   <= row_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign state = board_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule
